// File: rtl/calc_seq.sv
// calc_seq: keypad calculator core. Builds two unsigned decimal operands from
// strobed key codes, computes add/sub/mul (and div when CALC_DIV_EN is defined),
// then prints the current value to the display one digit per cycle (LSD first).
// Ports: clock/reset (async, active-high); cmd/cmd_valid key input;
//        status/data/pos/data_valid display side; state exposes the FSM (debug).
// Keys are only taken in WAIT_A/WAIT_B; anything strobed in CALC/PRINT/ERROR is dropped.
// Optional feature macro: CALC_DIV_EN (key 13 becomes a restoring divide).
module calc_seq #(
    parameter int NDIG = 8,
    parameter int W    = 27
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              cmd,
    input  logic                    cmd_valid,
    output logic [1:0]              status,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    data_valid,
    output logic [2:0]              state
);
    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAXV64 = pow10(NDIG) - 1;
    localparam logic [W-1:0]   MAXV  = W'(MAXV64);
    localparam logic [2*W-1:0] MAXV2 = (2*W)'(MAXV64);
    localparam int PW = $clog2(NDIG);
    localparam int CW = $clog2(W + NDIG) + 1;
    localparam int EW = W + 4;

    localparam logic [3:0] K_ADD = 4'd10;
    localparam logic [3:0] K_SUB = 4'd11;
    localparam logic [3:0] K_MUL = 4'd12;
    localparam logic [3:0] K_DIV = 4'd13;
    localparam logic [3:0] K_EQ  = 4'd14;
    localparam logic [3:0] K_BS  = 4'd15;

    generate
        if (W < 64 && ((64'd1 << W) <= MAXV64)) begin : g_width_check
            $error("calc_seq: W too narrow to hold 10^NDIG-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        WAIT_A = 3'b000,
        WAIT_B = 3'b001,
        CALC   = 3'b010,
        PRINT  = 3'b011,
        ERROR  = 3'b100
    } state_t;

    state_t         state_q, state_d, ret_q, ret_d;
    logic [W-1:0]   acc_q, acc_d, rega_q, rega_d, regb_q, regb_d;
    logic [W-1:0]   work_q, work_d, mpl_q, mpl_d;
    logic [3:0]     op_q, op_d;
    logic           fresh_q, fresh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] prod_q, prod_d, mcand_q, mcand_d;
`ifdef CALC_DIV_EN
    logic [W:0]     rem_q, rem_d;
    logic [W:0]     shifted;
`endif

    logic [EW-1:0]  ext;
    logic           digit_ok, is_op, last;
    logic [W-1:0]   digit_val;
    logic [2*W-1:0] res;
    logic           done, err;

    // Append the digit in a wider field so the limit test cannot wrap.
    assign ext       = {4'b0, acc_q} * EW'(10) + EW'(cmd);
    assign digit_ok  = fresh_q || (ext <= EW'(MAXV));
    assign digit_val = fresh_q ? W'(cmd) : ext[W-1:0];
    assign last      = (cnt_q == CW'(W - 1));
`ifdef CALC_DIV_EN
    assign is_op = (cmd >= K_ADD) && (cmd <= K_DIV);
`else
    assign is_op = (cmd >= K_ADD) && (cmd <= K_MUL);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_A;
            ret_q   <= WAIT_A;
            acc_q   <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
            work_q  <= '0;
            mpl_q   <= '0;
            op_q    <= '0;
            fresh_q <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
`ifdef CALC_DIV_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            acc_q   <= acc_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            work_q  <= work_d;
            mpl_q   <= mpl_d;
            op_q    <= op_d;
            fresh_q <= fresh_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
`ifdef CALC_DIV_EN
            rem_q   <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        acc_d   = acc_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        work_d  = work_q;
        mpl_d   = mpl_q;
        op_d    = op_q;
        fresh_d = fresh_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
`ifdef CALC_DIV_EN
        rem_d   = rem_q;
        shifted = '0;
`endif
        res     = '0;
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            WAIT_A, WAIT_B: begin
                if (cmd_valid) begin
                    if (cmd <= 4'd9) begin
                        // Digits that would exceed the display limit vanish silently.
                        if (digit_ok) begin
                            acc_d   = digit_val;
                            fresh_d = 1'b0;
                            work_d  = digit_val;
                            ret_d   = state_q;
                            cnt_d   = '0;
                            state_d = PRINT;
                        end
                    end else if (cmd == K_BS) begin
                        acc_d   = acc_q / W'(10);
                        fresh_d = 1'b0;
                        work_d  = acc_q / W'(10);
                        ret_d   = state_q;
                        cnt_d   = '0;
                        state_d = PRINT;
                    end else if (is_op) begin
                        op_d = cmd;
                        if (state_q == WAIT_A) begin
                            rega_d  = acc_q;
                            acc_d   = '0;
                            fresh_d = 1'b0;
                            work_d  = '0;
                            ret_d   = WAIT_B;
                            cnt_d   = '0;
                            state_d = PRINT;
                        end
                    end else if (cmd == K_EQ && state_q == WAIT_B) begin
                        regb_d  = acc_q;
                        cnt_d   = '0;
                        prod_d  = '0;
                        mcand_d = {{W{1'b0}}, rega_q};
                        // Shared shift register: multiplier bits for mul, dividend/quotient for div.
                        mpl_d   = (op_q == K_DIV) ? rega_q : acc_q;
`ifdef CALC_DIV_EN
                        rem_d   = '0;
`endif
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                cnt_d = cnt_q + CW'(1);
                case (op_q)
                    K_ADD: begin
                        res  = {{W{1'b0}}, rega_q} + {{W{1'b0}}, regb_q};
                        done = 1'b1;
                    end
                    K_SUB: begin
                        err  = (regb_q > rega_q);
                        res  = {{W{1'b0}}, rega_q - regb_q};
                        done = 1'b1;
                    end
                    K_MUL: begin
                        prod_d  = prod_q + (mpl_q[0] ? mcand_q : '0);
                        mcand_d = mcand_q << 1;
                        mpl_d   = mpl_q >> 1;
                        res     = prod_d;
                        done    = last;
                    end
`ifdef CALC_DIV_EN
                    K_DIV: begin
                        if (regb_q == '0) begin
                            err  = 1'b1;
                            done = 1'b1;
                        end else begin
                            // Restoring step: bring down the next dividend bit, subtract if it fits.
                            shifted = {rem_q[W-1:0], mpl_q[W-1]};
                            if (shifted >= {1'b0, regb_q}) begin
                                rem_d = shifted - {1'b0, regb_q};
                                mpl_d = {mpl_q[W-2:0], 1'b1};
                            end else begin
                                rem_d = shifted;
                                mpl_d = {mpl_q[W-2:0], 1'b0};
                            end
                            res  = {{W{1'b0}}, mpl_d};
                            done = last;
                        end
                    end
`endif
                    default: begin
                        err  = 1'b1;
                        done = 1'b1;
                    end
                endcase

                if (done) begin
                    if (err || res > MAXV2) begin
                        state_d = ERROR;
                    end else begin
                        acc_d   = res[W-1:0];
                        fresh_d = 1'b1;
                        work_d  = res[W-1:0];
                        ret_d   = WAIT_A;
                        cnt_d   = '0;
                        state_d = PRINT;
                    end
                end
            end

            PRINT: begin
                work_d = work_q / W'(10);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    cnt_d   = '0;
                    state_d = ret_q;
                end
            end

            default: ;  // ERROR: held until reset
        endcase
    end

    always_comb begin
        status     = 2'b10;
        data       = 4'd0;
        pos        = '0;
        data_valid = 1'b0;
        state      = state_q;
        case (state_q)
            CALC:  status = 2'b01;
            ERROR: status = 2'b00;
            PRINT: begin
                status     = 2'b11;
                data_valid = 1'b1;
                data       = 4'(work_q % W'(10));
                pos        = cnt_q[PW-1:0];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_calc_seq.sv
module tb_calc_seq;
    localparam int NDIG = 8;
    localparam int W    = 27;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic [1:0] status;
    logic [3:0] data;
    logic [2:0] pos;
    logic       data_valid;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    calc_seq #(.NDIG(NDIG), .W(W)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .status(status), .data(data), .pos(pos), .data_valid(data_valid), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Strobe one key; returns on the negedge after it was sampled.
    task automatic press(input logic [3:0] k);
        @(negedge clock);
        cmd = k;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Checks a full print burst starting at the current negedge. A key 7 is
    // strobed on cycle inj (use -1 for none) to confirm keys are dropped.
    task automatic expect_print(input longint unsigned val, input int inj, input string tag);
        longint unsigned v = val;
        for (int k = 0; k < NDIG; k++) begin
            if (k > 0) @(negedge clock);
            cmd = 4'd7;
            cmd_valid = (k == inj);
            chk(tag, {data_valid, pos, data}, 64'(128 + k * 16 + (v % 10)));
            v = v / 10;
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        chk({tag, "_end"}, {status, data_valid, pos}, 64'd32);
    endtask

    // Counts busy cycles, bounded so a stuck CALC still reaches the summary.
    task automatic wait_calc(input int exp_cyc, input string tag);
        int n = 0;
        while (status == 2'b01 && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk(tag, n, exp_cyc);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset", {state, status, data_valid, pos, data}, 64'd512);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        longint unsigned v;
        do_reset();

        // Entry of 1,2,3
        press(4'd1); expect_print(1, -1, "t1_d1");
        press(4'd2); expect_print(12, -1, "t1_d2");
        press(4'd3); expect_print(123, -1, "t1_d3");
        chk("t1_state", state, 0);

        // 45 + 17 = 62
        do_reset();
        press(4'd4); expect_print(4, -1, "t2_4");
        press(4'd5); expect_print(45, -1, "t2_45");
        press(4'd10); expect_print(0, -1, "t2_op");
        chk("t2_waitb", state, 1);
        press(4'd1); expect_print(1, -1, "t2_1");
        press(4'd7); expect_print(17, -1, "t2_17");
        press(4'd14); wait_calc(1, "t2_calc");
        expect_print(62, -1, "t2_res");
        chk("t2_state", state, 0);

        // 12, backspace, 7 -> 17 * 6 = 102, then chain + 8 = 110
        do_reset();
        press(4'd1); expect_print(1, -1, "t3_1");
        press(4'd2); expect_print(12, -1, "t3_12");
        press(4'd15); expect_print(1, -1, "t3_bs");
        press(4'd7); expect_print(17, -1, "t3_17");
        press(4'd12); expect_print(0, -1, "t3_op");
        press(4'd6); expect_print(6, -1, "t3_6");
        press(4'd14); wait_calc(W, "t3_mulcyc");
        expect_print(102, -1, "t3_res");
        press(4'd10); expect_print(0, -1, "t3_chain_op");
        press(4'd8); expect_print(8, -1, "t3_8");
        press(4'd14); wait_calc(1, "t3_calc2");
        expect_print(110, -1, "t3_chain");

        // 5 - 9 -> negative -> ERROR, sticky until reset
        do_reset();
        press(4'd5); expect_print(5, -1, "t4_5");
        press(4'd11); expect_print(0, -1, "t4_op");
        press(4'd9); expect_print(9, -1, "t4_9");
        press(4'd14); wait_calc(1, "t4_calc");
        chk("t4_err", {state, status, data_valid}, 64'b100_00_0);
        press(4'd1); press(4'd14);
        @(negedge clock);
        chk("t4_sticky", {state, status, data_valid}, 64'b100_00_0);
        do_reset();
        chk("t4_post", {state, status, data_valid}, 64'b000_10_0);

        // Async reset aborts a print mid-burst
        press(4'd3);
        do_reset();

        // Eight 9s fill the display; the ninth is discarded; then overflow
        do_reset();
        v = 0;
        for (int i = 0; i < NDIG; i++) begin
            v = v * 10 + 9;
            press(4'd9); expect_print(v, -1, "t5_fill");
        end
        press(4'd9);
        chk("t5_drop", {status, data_valid}, 64'b10_0);
        @(negedge clock);
        chk("t5_drop2", {state, data_valid}, 64'b000_0);
        press(4'd10); expect_print(0, -1, "t5_op");
        press(4'd1); expect_print(1, -1, "t5_1");
        press(4'd14); wait_calc(1, "t5_calc");
        chk("t5_ovf", {state, status}, 64'b100_00);

        // Key strobed mid-print is dropped
        do_reset();
        press(4'd4); expect_print(4, 3, "t6_inj");
        chk("t6_state", state, 0);
        press(4'd1); expect_print(41, -1, "t6_41");

`ifdef CALC_DIV_EN
        do_reset();
        press(4'd1); expect_print(1, -1, "dv_1");
        press(4'd0); expect_print(10, -1, "dv_10");
        press(4'd0); expect_print(100, -1, "dv_100");
        press(4'd13); expect_print(0, -1, "dv_op");
        press(4'd7); expect_print(7, -1, "dv_7");
        press(4'd14); wait_calc(W, "dv_cyc");
        expect_print(14, -1, "dv_res");
        do_reset();
        press(4'd5); expect_print(5, -1, "dz_5");
        press(4'd13); expect_print(0, -1, "dz_op");
        press(4'd0); expect_print(0, -1, "dz_0");
        press(4'd14); wait_calc(1, "dz_calc");
        chk("dz_err", {state, status}, 64'b100_00);
`else
        do_reset();
        press(4'd13);
        chk("nd_a", {state, status, data_valid}, 64'b000_10_0);
        @(negedge clock);
        chk("nd_a2", {state, status, data_valid}, 64'b000_10_0);
        press(4'd3); expect_print(3, -1, "nd_3");
        press(4'd10); expect_print(0, -1, "nd_op");
        press(4'd13);
        chk("nd_b", {state, status, data_valid}, 64'b001_10_0);
        press(4'd2); expect_print(2, -1, "nd_2");
        press(4'd14); wait_calc(1, "nd_calc");
        expect_print(5, -1, "nd_res");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
